// File: rtl/exc_pkg.sv
// Shared types and constants for the exception request controller.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAISE   = 2'd1,
    HANDLER = 2'd2
  } exc_state_t;

  localparam logic [3:0]  EXC_NONE   = 4'h0;
  localparam logic [63:0] EXC_VECTOR = 64'hD8;

  // Source i reports code i+1 so that code 0 can mean "no exception".
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/exc_controller_prio.sv
// Fixed-priority encoder for exception candidates: the lowest set index wins.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] cand,
  output logic            valid,
  output logic [3:0]      idx,
  output logic [NSRC-1:0] onehot
);

  always_comb begin
    valid  = |cand;
    onehot = cand & (~cand + NSRC'(1));
    idx    = 4'd0;
    for (int i = 0; i < NSRC; i++) begin
      idx = idx | ({4{onehot[i]}} & 4'(i));
    end
  end

endmodule

// File: rtl/exc_controller.sv
// Exception request arbiter/sequencer: IDLE -> RAISE -> HANDLER -> IDLE.
// Optional RAISE watchdog is enabled by defining EXC_CTRL_TIMEOUT_EN.
module exc_controller
  import exc_pkg::*;
#(
  parameter int NSRC    = 4,
  parameter int CODE_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   req,
  input  logic              ExcAck,
  input  logic              ERet,
  output logic              Exc,
  output logic [CODE_W-1:0] EStatus,
  output logic              in_handler,
  output logic [NSRC-1:0]   pending,
  output logic              exc_timeout
);

  exc_state_t        state_q, state_d;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [CODE_W-1:0] estatus_q, estatus_d;
  logic              exc_q, exc_d;
  logic              in_handler_q, in_handler_d;
  logic [NSRC-1:0]   grant_onehot;

  logic              enc_valid;
  logic [3:0]        enc_idx;
  logic [NSRC-1:0]   enc_onehot;

`ifdef EXC_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  exc_prio_enc #(.NSRC(NSRC)) u_prio (
    .cand   (pending_q | req),
    .valid  (enc_valid),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  always_comb begin
    state_d      = state_q;
    estatus_d    = estatus_q;
    grant_onehot = '0;
`ifdef EXC_CTRL_TIMEOUT_EN
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          grant_onehot = enc_onehot;
          estatus_d    = CODE_W'(code_of(enc_idx));
          state_d      = RAISE;
`ifdef EXC_CTRL_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RAISE: begin
        if (ExcAck) begin
          state_d = HANDLER;
        end else begin
`ifdef EXC_CTRL_TIMEOUT_EN
          // Abandon the grant; the source was already cleared from pending.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = RAISE;
          end
`else
          state_d = RAISE;
`endif
        end
      end
      HANDLER: begin
        if (ERet) begin
          state_d = IDLE;
        end else begin
          state_d = HANDLER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pending_d    = (pending_q | req) & ~grant_onehot;
    exc_d        = (state_d == RAISE);
    in_handler_d = (state_d == HANDLER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      estatus_q    <= CODE_W'(EXC_NONE);
      exc_q        <= 1'b0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      estatus_q    <= estatus_d;
      exc_q        <= exc_d;
      in_handler_q <= in_handler_d;
    end
  end

`ifdef EXC_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign exc_timeout = tmo_q;
`else
  assign exc_timeout = 1'b0;
`endif

  assign Exc        = exc_q;
  assign EStatus    = estatus_q;
  assign in_handler = in_handler_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_exc_controller.sv
// Self-checking bench for exc_controller: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the request/grant rules.
module tb_exc_controller;

  localparam int NSRC    = 4;
  localparam int CODE_W  = 4;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              reset;
  logic [NSRC-1:0]   req;
  logic              ExcAck;
  logic              ERet;
  logic              Exc;
  logic [CODE_W-1:0] EStatus;
  logic              in_handler;
  logic [NSRC-1:0]   pending;
  logic              exc_timeout;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = waiting, 1 = exception being raised, 2 = handler running.
  int              m_phase;
  int              m_code;
  logic [NSRC-1:0] m_pend;
  bit              m_tmo;
  int              m_rcnt;
  bit              chk_en;

  exc_controller #(.NSRC(NSRC), .CODE_W(CODE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ExcAck      (ExcAck),
    .ERet        (ERet),
    .Exc         (Exc),
    .EStatus     (EStatus),
    .in_handler  (in_handler),
    .pending     (pending),
    .exc_timeout (exc_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_code  = 0;
    m_pend  = '0;
    m_tmo   = 1'b0;
    m_rcnt  = 0;
  endtask

  task automatic model_step(input logic [NSRC-1:0] r, input logic a, input logic e);
    logic [NSRC-1:0] cand;
    int lo;
    cand = m_pend | r;
    m_pend = cand;
    if (m_phase == 0) begin
      if (cand != '0) begin
        lo = 0;
        for (int i = NSRC - 1; i >= 0; i--) if (cand[i]) lo = i;
        m_code  = lo + 1;
        m_pend[lo] = 1'b0;
        m_phase = 1;
        m_rcnt  = 0;
      end
    end else if (m_phase == 1) begin
      if (a) begin
        m_phase = 2;
      end else begin
`ifdef EXC_CTRL_TIMEOUT_EN
        m_rcnt++;
        if (m_rcnt == TIMEOUT) begin
          m_tmo   = 1'b1;
          m_phase = 0;
        end
`endif
      end
    end else begin
      if (e) m_phase = 0;
    end
  endtask

  task automatic step(input logic [NSRC-1:0] r, input logic a, input logic e);
    req    = r;
    ExcAck = a;
    ERet   = e;
    @(posedge clk);
    #1;
    model_step(r, a, e);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("Exc",         32'(Exc),         32'(m_phase == 1));
      chk("in_handler",  32'(in_handler),  32'(m_phase == 2));
      chk("EStatus",     32'(EStatus),     32'(m_code));
      chk("pending",     32'(pending),     32'(m_pend));
      chk("exc_timeout", 32'(exc_timeout), 32'(m_tmo));
    end
  end

  initial begin
    clk    = 1'b0;
    reset  = 1'b1;
    req    = '0;
    ExcAck = 1'b0;
    ERet   = 1'b0;
    chk_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Exc",     32'(Exc),         32'd0);
    chk("rst_EStatus", 32'(EStatus),     32'd0);
    chk("rst_pending", 32'(pending),     32'd0);
    chk("rst_inh",     32'(in_handler),  32'd0);
    chk("rst_tmo",     32'(exc_timeout), 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single request, ack, eret.
    step(4'b0100, 1'b0, 1'b0);
    chk("t1_Exc",     32'(Exc),     32'd1);
    chk("t1_EStatus", 32'(EStatus), 32'd3);
    chk("t1_pending", 32'(pending), 32'd0);
    step(4'b0000, 1'b1, 1'b0);
    chk("t1_ack_Exc", 32'(Exc),        32'd0);
    chk("t1_ack_inh", 32'(in_handler), 32'd1);
    step(4'b0000, 1'b0, 1'b1);
    chk("t1_eret_inh", 32'(in_handler), 32'd0);

    // Two requests at once: lower index first, other remains pending.
    step(4'b1010, 1'b0, 1'b0);
    chk("t2_EStatus", 32'(EStatus), 32'd2);
    chk("t2_pending", 32'(pending), 32'h8);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    chk("t2_idle_Exc", 32'(Exc), 32'd0);
    step(4'b0000, 1'b0, 1'b0);
    chk("t2_Exc2",     32'(Exc),     32'd1);
    chk("t2_EStatus2", 32'(EStatus), 32'd4);
    chk("t2_pending2", 32'(pending), 32'd0);
    step(4'b0000, 1'b1, 1'b0);

    // Request coinciding with ERet is granted from IDLE next cycle.
    step(4'b0001, 1'b0, 1'b1);
    chk("t3_Exc0", 32'(Exc),        32'd0);
    chk("t3_inh0", 32'(in_handler), 32'd0);
    step(4'b0000, 1'b0, 1'b0);
    chk("t3_Exc1",     32'(Exc),     32'd1);
    chk("t3_EStatus1", 32'(EStatus), 32'd1);

    // ERet during RAISE and ExcAck during IDLE are ignored.
    step(4'b0000, 1'b0, 1'b1);
    chk("t4_Exc_hold", 32'(Exc),        32'd1);
    chk("t4_inh_hold", 32'(in_handler), 32'd0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0);
    chk("t4_idle_Exc", 32'(Exc),        32'd0);
    chk("t4_idle_inh", 32'(in_handler), 32'd0);

    // Asynchronous reset in the middle of RAISE with requests pending.
    step(4'b0111, 1'b0, 1'b0);
    chk("t5_pending", 32'(pending), 32'h6);
    #2;
    req   = '0;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t5_Exc",     32'(Exc),     32'd0);
    chk("t5_EStatus", 32'(EStatus), 32'd0);
    chk("t5_pending", 32'(pending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // RAISE without an acknowledge.
    step(4'b0010, 1'b0, 1'b0);
    repeat (TIMEOUT - 1) step(4'b0000, 1'b0, 1'b0);
    chk("t6_Exc_before", 32'(Exc), 32'd1);
    step(4'b0000, 1'b0, 1'b0);
`ifdef EXC_CTRL_TIMEOUT_EN
    chk("t6_tmo",  32'(exc_timeout), 32'd1);
    chk("t6_Exc",  32'(Exc),         32'd0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    chk("t6_sticky", 32'(exc_timeout), 32'd1);
`else
    chk("t6_tmo",  32'(exc_timeout), 32'd0);
    chk("t6_Exc",  32'(Exc),         32'd1);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [NSRC-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
      step(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
